// File: rtl/alu_operand_loader_if.sv
// Switch/button inputs and registered operand outputs between the front panel and the ALU input stage.
// The master side drives switches and button; the slave (loader) drives operands and status.
interface alu_operand_loader_if;
  logic [3:0] sw;
  logic       btn;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] op;
  logic [1:0] stage;
  logic       valid;
  logic       err;

  modport master (output sw, btn, input a, b, op, stage, valid, err);
  modport slave  (input sw, btn, output a, b, op, stage, valid, err);
endinterface

// File: rtl/alu_operand_loader.sv
// ALU operand loader: synchronizes and debounces the push-button, then steps A -> B -> opcode -> SHOW.
// state   | meaning
// LOAD_A  | next press latches sw into a
// LOAD_B  | next press latches sw into b
// LOAD_OP | next press latches sw into op if legal (0..3), else pulses err
// SHOW    | a/b/op complete, valid high; next press returns to LOAD_A
module alu_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input logic                 clk,
  input logic                 rst,
  alu_operand_loader_if.slave bus
);

  localparam logic [1:0] ST_LOAD_A  = 2'd0;
  localparam logic [1:0] ST_LOAD_B  = 2'd1;
  localparam logic [1:0] ST_LOAD_OP = 2'd2;
  localparam logic [1:0] ST_SHOW    = 2'd3;

  logic [1:0]       sync_q;
  logic             btn_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_level_q, db_level_d;
  logic             db_prev_q;
  logic             press;

  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [2:0] op_q, op_d;
  logic [1:0] stage_q, stage_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;

  assign btn_s = sync_q[1];
  assign press = db_level_q & ~db_prev_q;

  // Any cycle where the synchronized level agrees with the accepted level restarts the count.
  always_comb begin
    cnt_d      = cnt_q;
    db_level_d = db_level_q;
    if (btn_s == db_level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      db_level_d = btn_s;
      cnt_d      = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    stage_d = stage_q;
    err_d   = 1'b0;
    if (press) begin
      case (stage_q)
        ST_LOAD_A: begin
          a_d     = bus.sw;
          stage_d = ST_LOAD_B;
        end
        ST_LOAD_B: begin
          b_d     = bus.sw;
          stage_d = ST_LOAD_OP;
        end
        ST_LOAD_OP: begin
          if (bus.sw[3:2] == 2'b00) begin
            op_d    = bus.sw[2:0];
            stage_d = ST_SHOW;
          end else begin
            err_d = 1'b1;
          end
        end
        default: stage_d = ST_LOAD_A;
      endcase
    end
    valid_d = (stage_d == ST_SHOW);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      db_level_q <= 1'b0;
      db_prev_q  <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      stage_q    <= ST_LOAD_A;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], bus.btn};
      cnt_q      <= cnt_d;
      db_level_q <= db_level_d;
      db_prev_q  <= db_level_q;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      stage_q    <= stage_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign bus.a     = a_q;
  assign bus.b     = b_q;
  assign bus.op    = op_q;
  assign bus.stage = stage_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader with a short debounce window and a scoreboard of expected loads.
module tb_alu_operand_loader;

  localparam int DB = 4;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [1:0] st;
    logic       v;
    logic       e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  logic [3:0] m_a = '0, m_b = '0;
  logic [2:0] m_op = '0;
  logic [1:0] m_stage = '0;

  logic [1:0] st_prev = '0;
  int         adv = 0;

  alu_operand_loader_if bus_if ();

  alu_operand_loader #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus_if.stage != st_prev) adv = adv + 1;
    st_prev = bus_if.stage;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour of one consumed press; returns the expected post-edge outputs.
  function automatic exp_t model_press(input logic [3:0] v);
    exp_t e;
    e.e = 1'b0;
    case (m_stage)
      2'd0: begin m_a = v; m_stage = 2'd1; end
      2'd1: begin m_b = v; m_stage = 2'd2; end
      2'd2: begin
        if (v < 4'd4) begin m_op = v[2:0]; m_stage = 2'd3; end
        else e.e = 1'b1;
      end
      default: m_stage = 2'd0;
    endcase
    e.a = m_a; e.b = m_b; e.op = m_op; e.st = m_stage; e.v = (m_stage == 2'd3);
    return e;
  endfunction

  task automatic check_outputs(input string pfx, input exp_t e);
    chk({pfx, "_a"}, 32'(bus_if.a), 32'(e.a));
    chk({pfx, "_b"}, 32'(bus_if.b), 32'(e.b));
    chk({pfx, "_op"}, 32'(bus_if.op), 32'(e.op));
    chk({pfx, "_stage"}, 32'(bus_if.stage), 32'(e.st));
    chk({pfx, "_valid"}, 32'(bus_if.valid), 32'(e.v));
    chk({pfx, "_err"}, 32'(bus_if.err), 32'(e.e));
  endtask

  // Called #1 after a posedge with btn low and debounced low.
  task automatic do_press(input logic [3:0] v);
    exp_t e;
    logic [1:0] st0;
    st0 = m_stage;
    sb.push_back(model_press(v));
    bus_if.sw  = v;
    bus_if.btn = 1'b1;
    repeat (2 + DB) @(posedge clk);
    #1 chk("early_stage", 32'(bus_if.stage), 32'(st0));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_outputs("load", e);
    @(posedge clk);
    #1 chk("err_clear", 32'(bus_if.err), 32'h0);
    bus_if.btn = 1'b0;
    repeat (DB + 4) @(posedge clk);
    #1 chk("release_stage", 32'(bus_if.stage), 32'(e.st));
  endtask

  initial begin
    exp_t e;
    int   adv0;
    bus_if.sw  = '0;
    bus_if.btn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    e = '0;
    check_outputs("reset", e);
    rst = 1'b0;

    // Full sequence 5 + 3, opcode add
    do_press(4'd5);
    do_press(4'd3);
    do_press(4'd0);
    // Wrap, reload, then illegal opcode and recovery
    do_press(4'd8);
    do_press(4'd9);
    do_press(4'd2);
    do_press(4'd6);
    chk("illegal_valid", 32'(bus_if.valid), 32'h0);
    do_press(4'd1);
    do_press(4'd4);
    do_press(4'd9);
    do_press(4'd2);
    do_press(4'd15);
    do_press(4'd3);
    chk("show_op", 32'(bus_if.op), 32'h3);
    do_press(4'd0);
    do_press(4'd7);
    chk("retain_b", 32'(bus_if.b), 32'h2);

    // Async reset in the middle of a debounce window in LOAD_B
    bus_if.sw  = 4'd4;
    bus_if.btn = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    e = '0;
    check_outputs("async_rst", e);
    bus_if.btn = 1'b0;
    m_a = '0; m_b = '0; m_op = '0; m_stage = '0;
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_outputs("post_rst", e);

    // Switch sweep without press
    for (int i = 0; i < 16; i++) begin
      bus_if.sw = 4'(i);
      @(posedge clk);
      #1;
      chk("sweep_a", 32'(bus_if.a), 32'h0);
      chk("sweep_stage", 32'(bus_if.stage), 32'h0);
      chk("sweep_valid", 32'(bus_if.valid), 32'h0);
    end

    // Bouncing button, then long hold
    bus_if.sw = 4'd12;
    adv0 = adv;
    sb.push_back(model_press(4'd12));
    for (int i = 0; i < 6; i++) begin
      bus_if.btn = (i % 2 == 0);
      @(posedge clk);
      #1;
    end
    bus_if.btn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    e = sb.pop_front();
    check_outputs("bounce", e);
    repeat (100) @(posedge clk);
    #1;
    chk("hold_stage", 32'(bus_if.stage), 32'h1);
    chk("bounce_adv", 32'(adv - adv0), 32'h1);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
Upstream input stage for the 4-bit FPGA ALU. It takes operand and opcode values from four slide switches and one push-button, debounces the button, and steps through a load sequence: A, then B, then opcode. It presents registered, stable a/b/op values to the ALU. It asserts valid once all three values are loaded, so the ALU result and 7-segment display only reflect a complete operand set.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before the synchronized button level is accepted (10 ms at 50 MHz). Must be ≥ 2.
CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of the debounce counter (derived; do not override).

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
sw  input  4  raw slide switches; value to load
btn  input  1  raw push-button, active-high, asynchronous to clk, may bounce
a  output  4  registered operand A to ALU
b  output  4  registered operand B to ALU
op  output  3  registered ALU opcode (0 add, 1 sub, 2 shift right, 3 shift left)
stage  output  2  current load stage for LEDs: 0 LOAD_A, 1 LOAD_B, 2 LOAD_OP, 3 SHOW
valid  output  1  high while in SHOW; a/b/op form a complete set
err  output  1  one-cycle pulse on an illegal opcode load attempt

Behaviour:
- Reset (async, rst=1): a=0, b=0, op=0, stage=0 (LOAD_A), valid=0, err=0.
  - Internal state also clears: synchronizer FFs, debounced level, counter, previous-level register.
  - Reset asserted mid-sequence discards any partial load. There is no pending press after release.
- Synchronizer: btn passes through 2 flip-flops (btn_s). Nothing else samples raw btn.
- Debounce:
  - Counter cnt increments each cycle while btn_s != db_level.
  - cnt clears to 0 on any cycle where btn_s == db_level, so a glitch restarts the count.
  - When cnt reaches DEBOUNCE_CYCLES-1 with btn_s still != db_level: db_level <= btn_s and cnt <= 0 on that edge.
- Press pulse: press = db_level & ~db_level_q. It is one cycle wide, rising edge only.
  - Holding the button produces exactly one press.
  - Release produces none.
- Latency:
  - A clean btn rise first seen at edge 0 gives btn_s=1 after edge 2 and db_level=1 after edge 2+DEBOUNCE_CYCLES.
  - press is high during the following cycle; the target register updates at the next edge.
  - Total: a/b/op/stage change at edge 3+DEBOUNCE_CYCLES.
- FSM, advancing only on press:
  - LOAD_A: a <= sw; go to LOAD_B.
  - LOAD_B: b <= sw; go to LOAD_OP.
  - LOAD_OP:
    - sw[3:2]==00: op <= sw[2:0]; go to SHOW.
    - Otherwise (values 4–15, unsupported by the ALU): op unchanged, stay in LOAD_OP, err=1 for exactly the cycle after the press.
  - SHOW: valid=1. On press go to LOAD_A and drop valid; a/b/op keep their values.
- Outputs a, b, op:
  - Change only on the edge that consumes a press in the matching stage.
  - They are never driven directly from sw.
- valid:
  - Registered, equal to (stage==3).
  - Rises on the same edge that loads op.
  - Falls on the same edge that leaves SHOW.
- Switch changes without a press have no effect in any stage.
- Presses arrive at least DEBOUNCE_CYCLES apart by construction, so there is no simultaneous-press case.
- stage wraps 3 -> 0; no other transitions exist. The 2-bit encoding is fully used.

Test Plan:
(Bench sets DEBOUNCE_CYCLES=4.)
1. Reset then full sequence:
   - Stimulus: sw=5 + press, sw=3 + press, sw=0 + press.
   - Required: a=5, b=3, op=0, stage=3, valid=1. The ALU shows 8 on hex displays.
   - Each update lands exactly 7 edges after btn rises.
2. Bounce:
   - Stimulus: btn toggles 1,0,1,0 every cycle for 6 cycles, then holds 1 for 10 cycles.
   - Required: exactly one press; stage advances 0->1 once.
   - Holding btn for 100 cycles gives no further advance.
3. Illegal opcode:
   - Stimulus: in LOAD_OP, sw=6 + press.
   - Required: err pulses 1 cycle, op stays 0, stage stays 2, valid=0.
   - Then sw=1 + press: op=1, valid=1, err=0.
4. Wrap and retain:
   - Stimulus: from SHOW with a=9, b=2, op=3, press.
   - Required: stage=0, valid=0, a/b/op unchanged. Then sw=7 + press: a=7, b still 2.
5. Async reset mid-debounce:
   - Stimulus: btn held 1 for 3 cycles in LOAD_B; assert rst between edges.
   - Required: outputs zero immediately, without waiting for a clock edge.
   - After release with btn=0, no press and stage stays 0.
6. Switch change without press:
   - Stimulus: sw sweeps 0..15 in LOAD_A.
   - Required: a, stage, and valid all constant.
